// File: rtl/i2s_sched_pkg.sv
// rtl/i2s_sched_pkg.sv - shared states and constants for the I2S memory request scheduler
package i2s_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_ISSUE,
    S_DATA,
    S_PAD,
    S_DONE
  } sched_state_t;

  localparam int MAX_BURST_DEFAULT = 64;
  localparam int PTR_WIDTH         = 24;
  localparam int AVAIL_WIDTH       = PTR_WIDTH + 1;
  localparam int LEN_WIDTH         = 9;
  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  function automatic logic [PTR_WIDTH-1:0] min_ptr(input logic [PTR_WIDTH-1:0] a,
                                                   input logic [PTR_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/i2s_ring_ptr.sv
// rtl/i2s_ring_ptr.sv - ring consume pointer with wrap increment and fill-level arithmetic
module i2s_ring_ptr
  import i2s_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance,
  input  logic [PTR_WIDTH-1:0] cfg_ring_size,
  input  logic [PTR_WIDTH-1:0] cfg_write_ptr,
  output logic [PTR_WIDTH-1:0] read_ptr,
  output logic [PTR_WIDTH-1:0] avail,
  output logic [PTR_WIDTH-1:0] to_end
);

  logic [AVAIL_WIDTH-1:0] diff;
  logic [AVAIL_WIDTH-1:0] wrapped;
  logic [AVAIL_WIDTH-1:0] ptr_inc;

  // One extra bit so a write pointer behind the read pointer folds back by ring size.
  always_comb begin
    diff    = {1'b0, cfg_write_ptr} - {1'b0, read_ptr};
    wrapped = diff[AVAIL_WIDTH-1] ? diff + {1'b0, cfg_ring_size} : diff;
    avail   = PTR_WIDTH'(wrapped);
    to_end  = (read_ptr < cfg_ring_size) ? cfg_ring_size - read_ptr : '0;
    ptr_inc = {1'b0, read_ptr} + AVAIL_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_ptr <= '0;
    end else if (advance) begin
      read_ptr <= (ptr_inc >= {1'b0, cfg_ring_size}) ? '0 : ptr_inc[PTR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/i2s_mem_request_scheduler.sv
// rtl/i2s_mem_request_scheduler.sv - splits FIFO fill requests into ring-bounded memory bursts, zero-padding on underrun
module i2s_mem_request_scheduler
  import i2s_sched_pkg::*;
#(
  parameter int MAX_BURST  = MAX_BURST_DEFAULT,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [23:0]           cfg_ring_size,
  input  logic [23:0]           cfg_write_ptr,
  output logic [23:0]           read_ptr,
  output logic [15:0]           underrun_count,
  output logic                  busy,
  input  logic                  request_data,
  input  logic [23:0]           request_size,
  output logic                  request_finished,
  output logic                  memory_data_strobe,
  output logic [31:0]           memory_data,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [8:0]            mem_rd_len,
  input  logic                  mem_rd_ack,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_valid
);

  sched_state_t state, state_nxt;

  logic [PTR_WIDTH-1:0] remaining;
  logic [PTR_WIDTH-1:0] avail;
  logic [PTR_WIDTH-1:0] to_end;
  logic [PTR_WIDTH-1:0] chunk;
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 advance;
  logic                 last_beat;

  i2s_ring_ptr u_ring_ptr (
    .clk           (clk),
    .rst           (rst),
    .advance       (advance),
    .cfg_ring_size (cfg_ring_size),
    .cfg_write_ptr (cfg_write_ptr),
    .read_ptr      (read_ptr),
    .avail         (avail),
    .to_end        (to_end)
  );

  assign advance    = (state == S_DATA) && mem_rd_valid;
  assign last_beat  = advance && (beats_left == LEN_WIDTH'(1));
  assign mem_rd_req = (state == S_ISSUE);

  // A burst never runs past the ring end nor past what the host has written.
  always_comb begin
    chunk = min_ptr(min_ptr(remaining, PTR_WIDTH'(MAX_BURST)), min_ptr(to_end, avail));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (request_data && enable && (request_size != '0)) state_nxt = S_PLAN;
      S_PLAN:  state_nxt = (chunk != '0) ? S_ISSUE : S_PAD;
      S_ISSUE: if (mem_rd_ack) state_nxt = S_DATA;
      S_DATA:  if (last_beat) state_nxt = (remaining == PTR_WIDTH'(1)) ? S_DONE : S_PLAN;
      S_PAD: begin
        if (remaining == PTR_WIDTH'(1)) state_nxt = S_DONE;
        else if (avail != '0)           state_nxt = S_PLAN;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_IDLE;
      remaining          <= '0;
      beats_left         <= '0;
      mem_rd_addr        <= '0;
      mem_rd_len         <= '0;
      memory_data        <= '0;
      memory_data_strobe <= 1'b0;
      request_finished   <= 1'b0;
      busy               <= 1'b0;
      underrun_count     <= '0;
    end else begin
      state              <= state_nxt;
      memory_data_strobe <= 1'b0;
      request_finished   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (state_nxt == S_PLAN) begin
            remaining <= request_size;
            busy      <= 1'b1;
          end
        end
        S_PLAN: begin
          mem_rd_addr <= cfg_base_addr + ADDR_WIDTH'(read_ptr);
          mem_rd_len  <= LEN_WIDTH'(chunk);
          beats_left  <= LEN_WIDTH'(chunk);
        end
        S_DATA: begin
          if (mem_rd_valid) begin
            memory_data        <= mem_rd_data;
            memory_data_strobe <= 1'b1;
            remaining          <= remaining - PTR_WIDTH'(1);
            beats_left         <= beats_left - LEN_WIDTH'(1);
          end
        end
        S_PAD: begin
          memory_data        <= '0;
          memory_data_strobe <= 1'b1;
          remaining          <= remaining - PTR_WIDTH'(1);
          if (underrun_count != UNDERRUN_MAX) underrun_count <= underrun_count + 16'd1;
        end
        S_DONE: begin
          request_finished <= 1'b1;
          busy             <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_mem_request_scheduler.sv
// tb/tb_i2s_mem_request_scheduler.sv - randomized self-checking bench for i2s_mem_request_scheduler
module tb_i2s_mem_request_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, busy, request_data, request_finished, memory_data_strobe;
  logic        mem_rd_req, mem_rd_ack, mem_rd_valid;
  logic [31:0] cfg_base_addr, memory_data, mem_rd_addr, mem_rd_data;
  logic [23:0] cfg_ring_size, cfg_write_ptr, read_ptr, request_size;
  logic [15:0] underrun_count;
  logic [8:0]  mem_rd_len;

  always #5 clk = ~clk;

  i2s_mem_request_scheduler #(.MAX_BURST(64), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_base_addr(cfg_base_addr), .cfg_ring_size(cfg_ring_size), .cfg_write_ptr(cfg_write_ptr),
    .read_ptr(read_ptr), .underrun_count(underrun_count), .busy(busy),
    .request_data(request_data), .request_size(request_size), .request_finished(request_finished),
    .memory_data_strobe(memory_data_strobe), .memory_data(memory_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
  );

  int tests = 0, fails = 0;
  int cyc = 0, fin_cnt = 0, fin_cyc = 0, last_strobe_cyc = 0, stab_err = 0;
  logic [31:0] got_words[$], exp_words[$], got_baddr[$], exp_baddr[$];
  int          got_blen[$], exp_blen[$];
  int          m_rp = 0, m_under = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [8:0]  prev_len = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Reference: take what the ring can supply in bounded bursts, pad the rest with zeros.
  task automatic model_request(input int n);
    int rem, avail, to_end, chunk, size, wp;
    size = int'(cfg_ring_size);
    wp   = int'(cfg_write_ptr);
    exp_words.delete(); exp_baddr.delete(); exp_blen.delete();
    rem = n;
    while (rem > 0) begin
      avail  = (wp - m_rp + size) % size;
      to_end = size - m_rp;
      chunk  = rem;
      if (chunk > 64)     chunk = 64;
      if (chunk > to_end) chunk = to_end;
      if (chunk > avail)  chunk = avail;
      if (chunk == 0) begin
        for (int i = 0; i < rem; i++) exp_words.push_back(32'h0);
        m_under = (m_under + rem > 65535) ? 65535 : m_under + rem;
        rem = 0;
      end else begin
        exp_baddr.push_back(cfg_base_addr + 32'(m_rp));
        exp_blen.push_back(chunk);
        for (int i = 0; i < chunk; i++) exp_words.push_back(mem_word(cfg_base_addr + 32'(m_rp + i)));
        m_rp = (m_rp + chunk) % size;
        rem -= chunk;
      end
    end
  endtask

  function automatic int words_bad();
    int b, n;
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    b = (got_words.size() > exp_words.size()) ? got_words.size() - exp_words.size()
                                              : exp_words.size() - got_words.size();
    for (int i = 0; i < n; i++) if (got_words[i] !== exp_words[i]) b++;
    return b;
  endfunction

  function automatic int bursts_bad();
    int b, n;
    n = (got_blen.size() < exp_blen.size()) ? got_blen.size() : exp_blen.size();
    b = (got_blen.size() > exp_blen.size()) ? got_blen.size() - exp_blen.size()
                                            : exp_blen.size() - got_blen.size();
    for (int i = 0; i < n; i++) if (got_blen[i] != exp_blen[i] || got_baddr[i] !== exp_baddr[i]) b++;
    return b;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (memory_data_strobe === 1'b1) begin
      got_words.push_back(memory_data);
      last_strobe_cyc = cyc;
    end
    if (request_finished === 1'b1) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    if (mem_rd_req === 1'b1 && prev_req && (mem_rd_addr !== prev_addr || mem_rd_len !== prev_len)) stab_err++;
    prev_req  = (mem_rd_req === 1'b1);
    prev_addr = mem_rd_addr;
    prev_len  = mem_rd_len;
  end

  // Burst read slave: random ack latency, random gaps between beats.
  initial begin
    logic [31:0] ba;
    int          bl;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && mem_rd_req === 1'b1) begin
        ba = mem_rd_addr;
        bl = int'(mem_rd_len);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        got_baddr.push_back(ba);
        got_blen.push_back(bl);
        mem_rd_ack = 1'b1;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        for (int i = 0; i < bl && rst === 1'b1; i++) begin
          repeat ($urandom_range(0, 1)) @(negedge clk);
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem_word(ba + 32'(i));
          @(negedge clk);
          mem_rd_valid = 1'b0;
        end
      end
    end
  end

  task automatic clear_obs();
    got_words.delete(); got_baddr.delete(); got_blen.delete();
    fin_cnt = 0;
  endtask

  task automatic start_request(input int n);
    @(negedge clk);
    request_size = 24'(n);
    request_data = 1'b1;
    @(negedge clk);
    request_data = 1'b0;
  endtask

  task automatic wait_finish(output bit to);
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (fin_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({read_ptr, underrun_count, busy, request_finished, memory_data_strobe, memory_data,
         mem_rd_req, mem_rd_addr, mem_rd_len} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: read_ptr=%0d busy=%b strobe=%b req=%b, required all 0",
               read_ptr, busy, memory_data_strobe, mem_rd_req);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mem_rd_req !== 1'b0 || read_ptr !== 24'd0 || memory_data_strobe !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b req=%b read_ptr=%0d, required 0/0/0", busy, mem_rd_req, read_ptr);
    end
  endtask

  task automatic test_basic();
    bit to;
    cfg_base_addr = 32'h0000_1000; cfg_ring_size = 24'd256; cfg_write_ptr = 24'd100;
    clear_obs(); model_request(100); start_request(100); wait_finish(to);
    tests++; if (to) begin fails++; $display("FAIL basic_timeout: finished=%0d, required 1", fin_cnt); end
    tests++; if (words_bad() != 0) begin fails++;
      $display("FAIL basic_words: got %0d words (%0d bad), required %0d", got_words.size(), words_bad(), exp_words.size()); end
    tests++;
    if (got_blen.size() != 2 || got_baddr[0] !== 32'h1000 || got_blen[0] != 64 ||
        got_baddr[1] !== 32'h1040 || got_blen[1] != 36) begin
      fails++; $display("FAIL basic_bursts: got %0d bursts, required 2 (64@0x1000, 36@0x1040)", got_blen.size());
    end
    tests++; if (fin_cnt != 1 || fin_cyc != last_strobe_cyc + 1) begin fails++;
      $display("FAIL basic_finish: pulses=%0d at cycle %0d, required 1 at cycle %0d", fin_cnt, fin_cyc, last_strobe_cyc + 1); end
    tests++; if (read_ptr !== 24'd100) begin fails++;
      $display("FAIL basic_read_ptr: got %0d, required 100", read_ptr); end
  endtask

  task automatic test_wrap();
    bit to;
    cfg_write_ptr = 24'd250;
    clear_obs(); model_request(150); start_request(150); wait_finish(to);
    tests++; if (to || words_bad() != 0 || read_ptr !== 24'd250) begin fails++;
      $display("FAIL wrap_prep: words bad=%0d read_ptr=%0d, required 0 bad and 250", words_bad(), read_ptr); end
    cfg_write_ptr = 24'd20;
    clear_obs(); model_request(20); start_request(20); wait_finish(to);
    tests++; if (to || words_bad() != 0) begin fails++;
      $display("FAIL wrap_words: got %0d words (%0d bad), required %0d", got_words.size(), words_bad(), exp_words.size()); end
    tests++;
    if (got_blen.size() != 2 || got_baddr[0] !== 32'h1000 + 32'd250 || got_blen[0] != 6 ||
        got_baddr[1] !== 32'h1000 || got_blen[1] != 14) begin
      fails++; $display("FAIL wrap_bursts: got %0d bursts, required 2 (6@base+250, 14@base+0)", got_blen.size());
    end
    tests++; if (read_ptr !== 24'd14) begin fails++; $display("FAIL wrap_read_ptr: got %0d, required 14", read_ptr); end
  endtask

  task automatic test_empty();
    bit to;
    cfg_write_ptr = 24'd14;
    clear_obs(); model_request(8); start_request(8); wait_finish(to);
    tests++; if (to || got_blen.size() != 0) begin fails++;
      $display("FAIL empty_no_read: timeout=%0d bursts=%0d, required 0 and 0", to, got_blen.size()); end
    tests++; if (words_bad() != 0 || got_words.size() != 8) begin fails++;
      $display("FAIL empty_pad: got %0d words (%0d bad), required 8 zero words", got_words.size(), words_bad()); end
    tests++; if (underrun_count !== 16'd8 || read_ptr !== 24'd14) begin fails++;
      $display("FAIL empty_counts: underrun=%0d read_ptr=%0d, required 8 and 14", underrun_count, read_ptr); end
  endtask

  task automatic test_partial();
    bit to;
    cfg_write_ptr = 24'd17;
    clear_obs(); model_request(10); start_request(10); wait_finish(to);
    tests++; if (to || words_bad() != 0 || got_words.size() != 10) begin fails++;
      $display("FAIL partial_words: got %0d words (%0d bad), required 10", got_words.size(), words_bad()); end
    tests++; if (got_blen.size() != 1 || got_blen[0] != 3 || got_baddr[0] !== 32'h1000 + 32'd14) begin fails++;
      $display("FAIL partial_burst: got %0d bursts, required 1 (3@base+14)", got_blen.size()); end
    tests++; if (underrun_count !== 16'd15 || read_ptr !== 24'd17) begin fails++;
      $display("FAIL partial_counts: underrun=%0d read_ptr=%0d, required 15 and 17", underrun_count, read_ptr); end
  endtask

  task automatic test_busy_enable();
    bit to;
    cfg_write_ptr = 24'd67;
    clear_obs(); model_request(40); start_request(40);
    for (int i = 0; i < 2000 && got_words.size() < 3; i++) @(negedge clk);
    request_size = 24'd5; request_data = 1'b1; enable = 1'b0;
    @(negedge clk);
    request_data = 1'b0;
    wait_finish(to);
    repeat (20) @(negedge clk);
    tests++; if (to || words_bad() != 0) begin fails++;
      $display("FAIL busy_words: got %0d words (%0d bad), required %0d", got_words.size(), words_bad(), exp_words.size()); end
    tests++; if (fin_cnt != 1 || busy !== 1'b0 || read_ptr !== 24'(m_rp)) begin fails++;
      $display("FAIL busy_finish: pulses=%0d busy=%b read_ptr=%0d, required 1/0/%0d", fin_cnt, busy, read_ptr, m_rp); end
    clear_obs(); start_request(4);
    repeat (20) @(negedge clk);
    tests++; if (got_words.size() != 0 || got_blen.size() != 0 || busy !== 1'b0) begin fails++;
      $display("FAIL disabled_ignore: words=%0d bursts=%0d busy=%b, required 0/0/0", got_words.size(), got_blen.size(), busy); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit started;
    cfg_write_ptr = 24'd200;
    clear_obs(); start_request(100);
    started = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (got_words.size() >= 5) begin started = 1'b1; break; end
    end
    tests++; if (!started) begin fails++; $display("FAIL rstmid_start: words=%0d, required 5", got_words.size()); end
    #3 rst = 1'b0;
    #1;
    tests++;
    if ({read_ptr, underrun_count, busy, request_finished, memory_data_strobe, memory_data,
         mem_rd_req, mem_rd_addr, mem_rd_len} !== '0) begin
      fails++;
      $display("FAIL rstmid_async: read_ptr=%0d busy=%b strobe=%b underrun=%0d, required all 0",
               read_ptr, busy, memory_data_strobe, underrun_count);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fin_cnt = 0;
    repeat (20) @(negedge clk);
    tests++; if (busy !== 1'b0 || mem_rd_req !== 1'b0 || read_ptr !== 24'd0 || fin_cnt != 0) begin fails++;
      $display("FAIL rstmid_idle: busy=%b req=%b read_ptr=%0d finished=%0d, required 0/0/0/0", busy, mem_rd_req, read_ptr, fin_cnt); end
    m_rp = 0; m_under = 0;
  endtask

  task automatic test_random();
    int size, n;
    bit to;
    size = $urandom_range(5, 300);
    cfg_ring_size = 24'(size);
    cfg_base_addr = $urandom;
    for (int k = 0; k < 12; k++) begin
      cfg_write_ptr = (k % 4 == 0) ? 24'(m_rp) : 24'($urandom_range(0, size - 1));
      n = $urandom_range(1, 200);
      clear_obs(); model_request(n); start_request(n); wait_finish(to);
      tests++; if (to || words_bad() != 0) begin fails++;
        $display("FAIL rand%0d_words: got %0d words (%0d bad), required %0d", k, got_words.size(), words_bad(), exp_words.size()); end
      tests++; if (bursts_bad() != 0) begin fails++;
        $display("FAIL rand%0d_bursts: got %0d bursts (%0d bad), required %0d", k, got_blen.size(), bursts_bad(), exp_blen.size()); end
      tests++; if (fin_cnt != 1 || fin_cyc != last_strobe_cyc + 1) begin fails++;
        $display("FAIL rand%0d_finish: pulses=%0d at %0d, required 1 at %0d", k, fin_cnt, fin_cyc, last_strobe_cyc + 1); end
      tests++; if (read_ptr !== 24'(m_rp) || underrun_count !== 16'(m_under)) begin fails++;
        $display("FAIL rand%0d_state: read_ptr=%0d underrun=%0d, required %0d and %0d", k, read_ptr, underrun_count, m_rp, m_under); end
    end
    tests++; if (stab_err != 0) begin fails++;
      $display("FAIL req_stability: %0d changes while request held, required 0", stab_err); end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; request_data = 1'b0; request_size = '0;
    cfg_base_addr = 32'h0000_1000; cfg_ring_size = 24'd256; cfg_write_ptr = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_empty();
    test_partial();
    test_busy_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_mem_request_scheduler.md
Name: i2s_mem_request_scheduler

Overview:
Services audio buffer-fill requests from the I2S memory controller by reading a host-managed circular sample buffer in system memory through a burst read master. Splits each request into bursts that never cross the ring end and never exceed MAX_BURST. Streams the returned words to the ping-pong FIFO write port. Zero-pads the transfer when the host has not supplied enough samples, so every request is always completed in full.

Parameters:
MAX_BURST, 64, maximum words per memory read burst (power of two, 1..256)
ADDR_WIDTH, 32, memory word-address width

Ports:
clk  in  1  system clock; the single clock for the whole block
rst  in  1  asynchronous, active-low reset
enable  in  1  scheduler enable
cfg_base_addr  in  ADDR_WIDTH  ring start word address
cfg_ring_size  in  24  ring length in words (>=1)
cfg_write_ptr  in  24  host fill pointer, word offset 0..cfg_ring_size-1
read_ptr  out  24  current consume offset
underrun_count  out  16  saturating count of zero-padded words
busy  out  1  transfer in progress
request_data  in  1  fill request pulse
request_size  in  24  words requested, sampled with request_data
request_finished  out  1  one-cycle pulse at transfer end
memory_data_strobe  out  1  one-cycle write strobe per word
memory_data  out  32  word to FIFO
mem_rd_req  out  1  burst request, held until ack
mem_rd_addr  out  ADDR_WIDTH  burst start address
mem_rd_len  out  9  burst length in words
mem_rd_ack  in  1  burst accepted
mem_rd_data  in  32  read data
mem_rd_valid  in  1  read data valid, exactly mem_rd_len beats per burst

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; read_ptr=0; state IDLE.
- avail = (cfg_write_ptr - read_ptr) mod cfg_ring_size, computed at 25 bits. avail==0 means empty; the ring holds at most cfg_ring_size-1 words.
- States:
  - IDLE: on request_data && enable && request_size!=0, latch remaining=request_size, busy=1, go to PLAN. Otherwise ignore. request_data is also ignored while busy. A request_size of 0 is ignored.
  - PLAN (1 cycle): chunk = min(remaining, MAX_BURST, cfg_ring_size-read_ptr, avail). If chunk>0, go to ISSUE. If chunk==0, go to PAD.
  - ISSUE: mem_rd_req=1, mem_rd_addr=cfg_base_addr+read_ptr, mem_rd_len=chunk. All are held stable until mem_rd_ack. On ack: drop req next cycle, go to DATA.
  - DATA: each mem_rd_valid gives memory_data=mem_rd_data and memory_data_strobe=1 in the following cycle (1-cycle registered latency). It also decrements remaining and beats_left, and advances read_ptr (wraps to 0 at cfg_ring_size). After the last beat: go to DONE if remaining==0, else go to PLAN.
  - PAD: one zero word per cycle (strobe=1, data=0). Each word decrements remaining and increments underrun_count, which saturates at 0xFFFF. read_ptr does not move. If avail becomes nonzero mid-pad, return to PLAN at the next word boundary. Go to DONE when remaining==0.
  - DONE: request_finished=1 for one cycle, busy=0, go to IDLE.
- enable deassert: IDLE-only gating. An in-flight transfer always completes, because the ppfifo buffer must be closed by request_finished.
- Config registers are sampled each PLAN. Changing them mid-transfer is legal but only affects the next burst.
- Exactly request_size strobes are emitted per request, in every case.

Decomposition:
- Shared package i2s_sched_pkg: state encodings (IDLE, PLAN, ISSUE, DATA, PAD, DONE), MAX_BURST default, mod-ring helper constants.
- One natural sub-module: i2s_ring_ptr. It holds read_ptr, performs wrap increment, and does the avail computation.

Test Plan:
- Setup: ring size 256, write_ptr 100, read_ptr 0, MAX_BURST 64. request_size 100 -> two bursts (64 at base+0, 36 at base+64); 100 strobes; request_finished one cycle after the last; read_ptr=100.
- Setup: read_ptr 250, write_ptr 20, ring 256. request_size 20 -> bursts of 6 at base+250 and 14 at base+0; read_ptr=14.
- Setup: write_ptr==read_ptr. request_size 8 -> no mem_rd_req; 8 zero words; underrun_count +8; read_ptr unchanged.
- Setup: avail 3. request_size 10 -> burst of 3, then 7 zero words; underrun_count +7; 10 strobes total.
- Stimulus: request_data pulses while busy, and enable drops mid-DATA -> the extra request is ignored, the transfer completes, and request_finished pulses once.
- Stimulus: rst asserted mid-DATA -> all outputs 0 asynchronously; after release, state is IDLE and read_ptr=0.
